// File: rtl/fc_result_writeback.sv
// rtl/fc_result_writeback.sv - FC result writeback: ReLU, rounding shift, saturation, 4-lane pack to BRAM
module fc_result_writeback #(
    parameter int CNT_BIT = 31,
    parameter int RWIDTH  = 32,
    parameter int OWIDTH  = 8,
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 12,
    parameter int SATW    = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_run,
    input  logic [CNT_BIT-1:0]       i_num_cnt,
    input  logic                     i_relu_en,
    input  logic [4:0]               i_shift,
    input  logic                     i_valid,
    input  logic signed [RWIDTH-1:0] i_result_0,
    input  logic signed [RWIDTH-1:0] i_result_1,
    input  logic signed [RWIDTH-1:0] i_result_2,
    input  logic signed [RWIDTH-1:0] i_result_3,
    output logic                     o_idle,
    output logic                     o_run,
    output logic                     o_done,
    output logic [SATW-1:0]          o_sat_cnt,
    output logic [AWIDTH-1:0]        addr_b3,
    output logic                     ce_b3,
    output logic                     we_b3,
    output logic [DWIDTH-1:0]        d_b3
);

    localparam int NLANE = 4;
    localparam logic signed [RWIDTH:0] SAT_MAX = (RWIDTH+1)'((2 ** (OWIDTH-1)) - 1);
    localparam logic signed [RWIDTH:0] SAT_MIN = -SAT_MAX - (RWIDTH+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CNT_BIT-1:0] num_cnt;
    logic [CNT_BIT-1:0] in_cnt;
    logic [CNT_BIT-1:0] wr_cnt;
    logic               cfg_relu;
    logic [4:0]         cfg_shift;

    logic start;
    logic accept;
    logic last_in;
    logic last_wr;

    logic signed [RWIDTH-1:0] lane_in [NLANE];
    logic signed [RWIDTH:0]   s1_y    [NLANE];
    logic                     s1_valid;

    logic [OWIDTH-1:0] lane_q   [NLANE];
    logic [NLANE-1:0]  lane_sat;
    logic [DWIDTH-1:0] d_nxt;
    logic [2:0]        n_sat;
    logic [SATW:0]     sat_sum;

    // ReLU then round-half-up arithmetic shift; one extra bit keeps the rounding add from overflowing
    function automatic logic signed [RWIDTH:0] scale(
        input logic signed [RWIDTH-1:0] r,
        input logic                     relu,
        input logic [4:0]               sh
    );
        logic signed [RWIDTH:0] x;
        logic signed [RWIDTH:0] rnd;
        x   = (relu && r[RWIDTH-1]) ? '0 : {r[RWIDTH-1], r};
        rnd = '0;
        if (sh != 5'd0)
            rnd[sh - 5'd1] = 1'b1;
        scale = (sh == 5'd0) ? x : ((x + rnd) >>> sh);
    endfunction

    // Returns {saturated, clamped lane}
    function automatic logic [OWIDTH:0] clamp(input logic signed [RWIDTH:0] y);
        if (y > SAT_MAX)
            clamp = {1'b1, SAT_MAX[OWIDTH-1:0]};
        else if (y < SAT_MIN)
            clamp = {1'b1, SAT_MIN[OWIDTH-1:0]};
        else
            clamp = {1'b0, y[OWIDTH-1:0]};
    endfunction

    assign lane_in[0] = i_result_0;
    assign lane_in[1] = i_result_1;
    assign lane_in[2] = i_result_2;
    assign lane_in[3] = i_result_3;

    assign start   = (state == ST_IDLE) && i_run;
    assign accept  = (state == ST_RUN) && i_valid;
    assign last_in = accept && (in_cnt == num_cnt - CNT_BIT'(1));
    assign last_wr = ce_b3 && (wr_cnt == num_cnt - CNT_BIT'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_run)
                    state_nxt = (i_num_cnt == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (last_in)
                    state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (last_wr)
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_idle = 1'b0;
        o_run  = 1'b0;
        o_done = 1'b0;
        case (state)
            ST_IDLE:  o_idle = 1'b1;
            ST_RUN:   o_run  = 1'b1;
            ST_FLUSH: o_run  = 1'b1;
            ST_DONE:  o_done = 1'b1;
            default:  o_idle = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_cnt   <= '0;
            cfg_relu  <= 1'b0;
            cfg_shift <= '0;
            in_cnt    <= '0;
            wr_cnt    <= '0;
        end else if (start) begin
            num_cnt   <= i_num_cnt;
            cfg_relu  <= i_relu_en;
            cfg_shift <= i_shift;
            in_cnt    <= '0;
            wr_cnt    <= '0;
        end else begin
            if (accept)
                in_cnt <= in_cnt + CNT_BIT'(1);
            if (ce_b3)
                wr_cnt <= wr_cnt + CNT_BIT'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < NLANE; k++)
                s1_y[k] <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                for (int k = 0; k < NLANE; k++)
                    s1_y[k] <= scale(lane_in[k], cfg_relu, cfg_shift);
            end
        end
    end

    // Lane 0 lands in the most significant byte of the packed word
    always_comb begin
        d_nxt = '0;
        n_sat = '0;
        for (int k = 0; k < NLANE; k++) begin
            {lane_sat[k], lane_q[k]} = clamp(s1_y[k]);
            d_nxt[DWIDTH-1-k*OWIDTH -: OWIDTH] = lane_q[k];
            n_sat = n_sat + 3'(lane_sat[k]);
        end
        sat_sum = {1'b0, o_sat_cnt} + (SATW+1)'(n_sat);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ce_b3     <= 1'b0;
            d_b3      <= '0;
            o_sat_cnt <= '0;
        end else begin
            ce_b3 <= s1_valid;
            if (s1_valid)
                d_b3 <= d_nxt;
            if (start)
                o_sat_cnt <= '0;
            else if (s1_valid)
                o_sat_cnt <= sat_sum[SATW] ? '1 : sat_sum[SATW-1:0];
        end
    end

    assign we_b3   = ce_b3;
    assign addr_b3 = wr_cnt[AWIDTH-1:0];

endmodule

// File: tb/tb_fc_result_writeback.sv
// tb/tb_fc_result_writeback.sv - directed self-checking bench for fc_result_writeback
module tb_fc_result_writeback;

    logic               clk;
    logic               reset_n;
    logic               i_run;
    logic [30:0]        i_num_cnt;
    logic               i_relu_en;
    logic [4:0]         i_shift;
    logic               i_valid;
    logic signed [31:0] r0, r1, r2, r3;

    logic        o_idle, o_run, o_done;
    logic [15:0] o_sat_cnt;
    logic [11:0] addr_b3;
    logic        ce_b3, we_b3;
    logic [31:0] d_b3;

    logic        idle2, run2, done2;
    logic [15:0] sat2;
    logic [1:0]  addr2;
    logic        ce2, we2;
    logic [31:0] d2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_n   = 0;
    int done_cyc = 0;
    int last_wr_cyc = 0;
    logic [31:0] aq [$];
    logic [31:0] dq [$];
    logic [31:0] aq2 [$];

    fc_result_writeback dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .i_relu_en(i_relu_en), .i_shift(i_shift), .i_valid(i_valid),
        .i_result_0(r0), .i_result_1(r1), .i_result_2(r2), .i_result_3(r3),
        .o_idle(o_idle), .o_run(o_run), .o_done(o_done), .o_sat_cnt(o_sat_cnt),
        .addr_b3(addr_b3), .ce_b3(ce_b3), .we_b3(we_b3), .d_b3(d_b3)
    );

    fc_result_writeback #(.AWIDTH(2)) dut_small (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .i_relu_en(i_relu_en), .i_shift(i_shift), .i_valid(i_valid),
        .i_result_0(r0), .i_result_1(r1), .i_result_2(r2), .i_result_3(r3),
        .o_idle(idle2), .o_run(run2), .o_done(done2), .o_sat_cnt(sat2),
        .addr_b3(addr2), .ce_b3(ce2), .we_b3(we2), .d_b3(d2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we_b3) begin
            aq.push_back(32'(addr_b3));
            dq.push_back(d_b3);
            last_wr_cyc = cyc;
        end
        if (we2)
            aq2.push_back(32'(addr2));
        if (o_done) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lanes(input int a, input int b, input int c, input int d);
        r0 = a; r1 = b; r2 = c; r3 = d;
    endtask

    task automatic clear_log();
        aq.delete(); dq.delete(); aq2.delete();
        done_n = 0;
    endtask

    task automatic start(input int n, input logic relu, input logic [4:0] sh);
        clear_log();
        i_run = 1'b1; i_num_cnt = 31'(n); i_relu_en = relu; i_shift = sh;
        tick();
        i_run = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset_n = 1'b0; i_run = 1'b0; i_num_cnt = '0; i_relu_en = 1'b0;
        i_shift = '0; i_valid = 1'b0;
        lanes(0, 0, 0, 0);
        wait_cycles(2);
        @(negedge clk);
        check("rst_idle", 32'(o_idle), 1);
        check("rst_run", 32'(o_run), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_sat", 32'(o_sat_cnt), 0);
        check("rst_addr", 32'(addr_b3), 0);
        check("rst_ce", {30'd0, ce_b3, we_b3}, 0);
        check("rst_data", d_b3, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // basic pack, four back-to-back words
        start(4, 1'b0, 5'd0);
        check("t2_run", 32'(o_run), 1);
        i_valid = 1'b1;
        lanes(5, -3, 127, -128);
        wait_cycles(4);
        i_valid = 1'b0;
        wait_cycles(10);
        check("t2_nwr", aq.size(), 4);
        for (int i = 0; i < aq.size(); i++) begin
            check("t2_addr", aq[i], i);
            check("t2_data", dq[i], 32'h05FD7F80);
        end
        check("t2_done_n", done_n, 1);
        check("t2_done_lat", done_cyc - last_wr_cyc, 1);
        check("t2_sat", 32'(o_sat_cnt), 0);
        check("t2_idle", 32'(o_idle), 1);

        // saturation with and without ReLU
        start(1, 1'b1, 5'd0);
        i_valid = 1'b1; lanes(300, -300, -1, 128);
        tick();
        i_valid = 1'b0;
        wait_cycles(6);
        check("t3a_nwr", aq.size(), 1);
        check("t3a_data", dq.size() > 0 ? dq[0] : 32'hx, 32'h7F00007F);
        check("t3a_sat", 32'(o_sat_cnt), 2);

        start(1, 1'b0, 5'd0);
        i_valid = 1'b1; lanes(300, -300, -1, 128);
        tick();
        i_valid = 1'b0;
        wait_cycles(6);
        check("t3b_data", dq.size() > 0 ? dq[0] : 32'hx, 32'h7F80FF7F);
        check("t3b_sat", 32'(o_sat_cnt), 3);

        // rounding shift
        start(1, 1'b0, 5'd2);
        i_valid = 1'b1; lanes(6, 5, -6, -7);
        tick();
        i_valid = 1'b0;
        wait_cycles(6);
        check("t4_data", dq.size() > 0 ? dq[0] : 32'hx, 32'h0201FFFE);
        check("t4_sat", 32'(o_sat_cnt), 0);

        // gapped valids, extras after the last accept, i_run while busy
        start(3, 1'b0, 5'd0);
        i_valid = 1'b1; lanes(1, 1, 1, 1);
        tick();
        i_valid = 1'b0; i_run = 1'b1; i_num_cnt = 31'd9;
        tick();
        i_run = 1'b0;
        i_valid = 1'b1; lanes(2, 2, 2, 2);
        tick();
        i_valid = 1'b0;
        tick();
        i_valid = 1'b1; lanes(3, 3, 3, 3);
        tick();
        lanes(50, 50, 50, 50);
        wait_cycles(2);
        i_valid = 1'b0;
        wait_cycles(12);
        check("t5_nwr", aq.size(), 3);
        for (int i = 0; i < aq.size(); i++) begin
            check("t5_addr", aq[i], i);
            check("t5_data", dq[i], {4{8'(i + 1)}});
        end
        check("t5_done_n", done_n, 1);
        check("t5_idle", 32'(o_idle), 1);

        // zero-length run
        start(0, 1'b0, 5'd0);
        @(negedge clk);
        check("t6a_done", 32'(o_done), 1);
        tick();
        @(negedge clk);
        check("t6a_done_off", 32'(o_done), 0);
        check("t6a_idle", 32'(o_idle), 1);
        wait_cycles(3);
        check("t6a_nwr", aq.size(), 0);

        // address wrap on the 2-bit-address instance
        start(6, 1'b0, 5'd0);
        i_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lanes(i, i, i, i);
            tick();
        end
        i_valid = 1'b0;
        wait_cycles(8);
        check("t6b_nwr2", aq2.size(), 6);
        for (int i = 0; i < aq2.size(); i++)
            check("t6b_addr2", aq2[i], i % 4);
        check("t6b_nwr", aq.size(), 6);
        check("t6b_last_addr", aq.size() > 0 ? aq[aq.size()-1] : 32'hx, 5);

        // reset mid-stream aborts the run
        start(8, 1'b0, 5'd0);
        i_valid = 1'b1; lanes(7, 7, 7, 7);
        wait_cycles(2);
        reset_n = 1'b0;
        i_valid = 1'b0;
        clear_log();
        @(negedge clk);
        check("t1_ce", 32'(ce_b3), 0);
        check("t1_idle", 32'(o_idle), 1);
        check("t1_run", 32'(o_run), 0);
        check("t1_addr", 32'(addr_b3), 0);
        check("t1_data", d_b3, 0);
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(8);
        check("t1_nwr", aq.size(), 0);
        check("t1_idle_after", 32'(o_idle), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
